// File: rtl/imem_loader.sv
// Instruction memory loader: receives a byte stream over valid/ready, packs
// four bytes into each little-endian 32-bit word and writes the words to the
// instruction store at consecutive word-aligned addresses. The core is held in
// reset (CpuReset=1) until the whole program has been written.
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//   When defined, a running XOR of all data bytes is compared against one
//   trailing checksum byte. A mismatch parks the loader in ERROR with Err=1.
module imem_loader #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [DEPTH_LOG2:0]   WordCount,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WE,
    output logic [31:0]           WA,
    output logic [31:0]           WD,
    output logic                  Busy,
    output logic                  Done,
    output logic                  CpuReset,
    output logic                  Err
);

`ifdef IMEM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;
    localparam state_t FINAL = CHECK;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam state_t FINAL = DONE;
`endif

    localparam logic [DEPTH_LOG2:0] MAX_CNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);

    state_t                state, state_nxt;
    logic [DEPTH_LOG2:0]   cnt;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            byte_idx;
    logic [31:0]           wa_r;
    logic [31:0]           wd_r;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic                  xfer;
    logic                  start_ok;
    logic [DEPTH_LOG2:0]   start_cnt;
    logic                  last_word;

    assign xfer      = ByteValid && ByteReady;
    assign start_ok  = Start && (state == IDLE || state == DONE
`ifdef IMEM_LOAD_CHECKSUM_EN
                                 || state == ERROR
`endif
                                );
    // Requests larger than the store are clipped so word_idx never wraps.
    assign start_cnt = (WordCount > MAX_CNT) ? MAX_CNT : WordCount;
    assign last_word = ({1'b0, word_idx} + (DEPTH_LOG2 + 1)'(1)) >= cnt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt = state;
        ByteReady = 1'b0;
        WE        = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        CpuReset  = 1'b1;
        Err       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (state == DONE) begin
                    Done     = 1'b1;
                    CpuReset = 1'b0;
                end
                if (Start) state_nxt = (start_cnt != '0) ? RECV : FINAL;
            end
            RECV: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (xfer && byte_idx == 2'd3) state_nxt = WRITE;
            end
            WRITE: begin
                WE        = 1'b1;
                Busy      = 1'b1;
                state_nxt = last_word ? FINAL : RECV;
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK: begin
                ByteReady = 1'b1;
                Busy      = 1'b1;
                if (xfer) state_nxt = (ByteIn == csum) ? DONE : ERROR;
            end
            ERROR: begin
                Err = 1'b1;
                if (Start) state_nxt = (start_cnt != '0) ? RECV : FINAL;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: counters, byte packing, write address and checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            wa_r     <= '0;
            wd_r     <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (start_ok) begin
                cnt      <= start_cnt;
                word_idx <= '0;
                byte_idx <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == RECV && xfer) begin
                wd_r[{byte_idx, 3'b000} +: 8] <= ByteIn;
                byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                csum     <= csum ^ ByteIn;
`endif
                // Address is captured with the last byte so it is stable
                // throughout the following write cycle.
                if (byte_idx == 2'd3) wa_r <= 32'({word_idx, 2'b00});
            end
            if (state == WRITE && !last_word) word_idx <= word_idx + 1'b1;
        end
    end

    assign WA = wa_r;
    assign WD = wd_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (DEPTH_LOG2 = 4).
module tb_imem_loader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [D:0]  WordCount;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady, WE, Busy, Done, CpuReset, Err;
    logic [31:0] WA, WD;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  tb_csum;

    imem_loader #(.DEPTH_LOG2(D)) dut (
        .clk(clk), .reset(reset), .Start(Start), .WordCount(WordCount),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .WE(WE), .WA(WA), .WD(WD), .Busy(Busy), .Done(Done),
        .CpuReset(CpuReset), .Err(Err)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (WE === 1'b1) begin
            wa_q.push_back(WA);
            wd_q.push_back(WD);
        end
    end

    task automatic do_reset();
        reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00; WordCount = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [D:0] wc);
        WordCount = wc;
        Start     = 1'b1;
        @(negedge clk);
        Start     = 1'b0;
        tb_csum   = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        ByteIn    = b;
        ByteValid = 1'b1;
        while (ByteReady !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (ByteReady !== 1'b1) begin
            n_total++;
            $display("FAIL send_byte_timeout: ByteReady=%b required 1", ByteReady);
        end else begin
            tb_csum = tb_csum ^ b;
        end
        @(negedge clk);
        ByteValid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
`ifdef IMEM_LOAD_CHECKSUM_EN
        send_byte(tb_csum);
`endif
        t = 0;
        while (Done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (Done !== 1'b1) begin
            n_total++;
            $display("FAIL wait_done_timeout: Done=%b required 1", Done);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if ({ByteReady, WE, Busy, Done, CpuReset, Err} !== 6'b000010)
            $display("FAIL %s_flags: {ByteReady,WE,Busy,Done,CpuReset,Err}=%b required 000010",
                     tag, {ByteReady, WE, Busy, Done, CpuReset, Err});
        else n_pass++;
        n_total++;
        if (WA !== 32'h0) $display("FAIL %s_WA: got %h required 00000000", tag, WA);
        else n_pass++;
        n_total++;
        if (WD !== 32'h0) $display("FAIL %s_WD: got %h required 00000000", tag, WD);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("por");
        pulse_start(5'd2);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
        do_reset();
        check_reset_outputs("midrun");
    endtask

    task automatic test_basic(input int gap);
        logic [7:0] stream [8];
        stream = '{8'h00, 8'h20, 8'h02, 8'hE2, 8'h00, 8'h30, 8'h82, 8'hE3};
        wa_q.delete(); wd_q.delete();
        pulse_start(5'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(stream[i]);
            repeat (gap) @(negedge clk);
        end
        wait_done();
        n_total++;
        if (wa_q.size() != 2) $display("FAIL basic_gap%0d_count: got %0d required 2", gap, wa_q.size());
        else n_pass++;
        n_total++;
        if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hE2022000)
            $display("FAIL basic_gap%0d_w0: WA=%h WD=%h required 00000000 E2022000", gap, wa_q[0], wd_q[0]);
        else n_pass++;
        n_total++;
        if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'hE3823000)
            $display("FAIL basic_gap%0d_w1: WA=%h WD=%h required 00000004 E3823000", gap, wa_q[1], wd_q[1]);
        else n_pass++;
        n_total++;
        if ({Done, CpuReset, Busy, ByteReady, Err} !== 5'b10000)
            $display("FAIL basic_gap%0d_done: {Done,CpuReset,Busy,ByteReady,Err}=%b required 10000",
                     gap, {Done, CpuReset, Busy, ByteReady, Err});
        else n_pass++;
    endtask

    task automatic test_zero_and_busy();
        logic [7:0] saved;
        do_reset();
        wa_q.delete(); wd_q.delete();
        pulse_start(5'd0);
`ifndef IMEM_LOAD_CHECKSUM_EN
        n_total++;
        if (Done !== 1'b1 || CpuReset !== 1'b0)
            $display("FAIL zero_done_next: Done=%b CpuReset=%b required 1 0", Done, CpuReset);
        else n_pass++;
`endif
        wait_done();
        n_total++;
        if (wa_q.size() != 0) $display("FAIL zero_no_we: writes=%0d required 0", wa_q.size());
        else n_pass++;

        pulse_start(5'd1);
        send_byte(8'hA1); send_byte(8'hB2);
        saved = tb_csum;
        pulse_start(5'd3);
        tb_csum = saved;
        n_total++;
        if (Busy !== 1'b1) $display("FAIL busy_start_ignored: Busy=%b required 1", Busy);
        else n_pass++;
        send_byte(8'hC3); send_byte(8'hD4);
        wait_done();
        n_total++;
        if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'hD4C3B2A1)
            $display("FAIL busy_single_write: n=%0d WA=%h WD=%h required 1 00000000 D4C3B2A1",
                     wa_q.size(), wa_q[0], wd_q[0]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        wa_q.delete(); wd_q.delete();
        pulse_start(5'd20);
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        wait_done();
        n_total++;
        if (wa_q.size() != 16) $display("FAIL overflow_count: got %0d required 16", wa_q.size());
        else n_pass++;
        n_total++;
        if (wd_q[0] !== 32'h03020100) $display("FAIL overflow_first_wd: got %h required 03020100", wd_q[0]);
        else n_pass++;
        n_total++;
        if (wa_q[15] !== 32'h3C || wd_q[15] !== 32'h3F3E3D3C)
            $display("FAIL overflow_last: WA=%h WD=%h required 0000003C 3F3E3D3C", wa_q[15], wd_q[15]);
        else n_pass++;
        n_total++;
        if (Done !== 1'b1 || ByteReady !== 1'b0)
            $display("FAIL overflow_done: Done=%b ByteReady=%b required 1 0", Done, ByteReady);
        else n_pass++;
    endtask

    task automatic test_reset_midload();
        wa_q.delete(); wd_q.delete();
        pulse_start(5'd2);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h02); send_byte(8'hE2);
        send_byte(8'h00); send_byte(8'h30);
        do_reset();
        check_reset_outputs("midload");
        wa_q.delete(); wd_q.delete();
        pulse_start(5'd1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_done();
        n_total++;
        if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h44332211)
            $display("FAIL reload_write: n=%0d WA=%h WD=%h required 1 00000000 44332211",
                     wa_q.size(), wa_q[0], wd_q[0]);
        else n_pass++;
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum_error();
        pulse_start(5'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F ^ 8'hFF);
        @(negedge clk);
        n_total++;
        if ({Err, Done, CpuReset, Busy} !== 4'b1010)
            $display("FAIL checksum_error: {Err,Done,CpuReset,Busy}=%b required 1010",
                     {Err, Done, CpuReset, Busy});
        else n_pass++;
        pulse_start(5'd0);
        n_total++;
        if (Err !== 1'b0) $display("FAIL checksum_err_cleared: Err=%b required 0", Err);
        else n_pass++;
        wait_done();
    endtask
`endif

    initial begin
        reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00; WordCount = '0;
        tb_csum = 8'h00;
        test_reset();
        test_basic(0);
        test_basic(3);
        test_zero_and_busy();
        test_overflow();
        test_reset_midload();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum_error();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
